// File: rtl/riscv_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshake plus the registered writeback port.
interface riscv_wb_arbiter_if #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_we;
  logic [5*NREQ-1:0]    req_addr;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wb_stall;
  logic                 wb_valid;
  logic                 wb_we;
  logic [4:0]           wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic [SW-1:0]        wb_src;
  logic [15:0]          contention_cnt;

  // Producers and the register file side
  modport master (
    output req_valid, req_we, req_addr, req_data, wb_stall,
    input  req_ready, wb_valid, wb_we, wb_addr, wb_data, wb_src, contention_cnt
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_data, wb_stall,
    output req_ready, wb_valid, wb_we, wb_addr, wb_data, wb_src, contention_cnt
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Round-robin arbiter for the shared integer register-file writeback port.
// Registers the winner onto wb_*, filters x0 writes, honours wb_stall and
// counts contended accept cycles (saturating).
module riscv_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               rstn,
  riscv_wb_arbiter_if.slave  bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [SW-1:0]   last;
  logic            accept;
  logic            contended;
  logic            grant_any;
  logic [NREQ-1:0] grant;
  logic [SW-1:0]   grant_idx;
  logic            sel_we;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;

  // Slot can take a new writeback when empty or draining this cycle
  always_comb begin
    accept    = !bus.wb_valid || !bus.wb_stall;
    contended = $countones(bus.req_valid) > 1;
  end

  // Rotating priority: indices above last first, then wrap to 0..last
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && bus.req_valid[i] && (SW'(i) > last)) begin
        grant_any = 1'b1;
        grant_idx = SW'(i);
        grant[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && bus.req_valid[i] && (SW'(i) <= last)) begin
        grant_any = 1'b1;
        grant_idx = SW'(i);
        grant[i]  = 1'b1;
      end
    end
  end

  // One-hot AND-OR mux of the granted request fields
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_we   = sel_we   | bus.req_we[i];
        sel_addr = sel_addr | bus.req_addr[5*i +: 5];
        sel_data = sel_data | bus.req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Grants are only visible when the slot accepts and reset is released
  always_comb begin
    bus.req_ready = (accept && rstn) ? grant : '0;
  end

  // Writeback register, round-robin pointer and contention counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.wb_valid       <= 1'b0;
      bus.wb_we          <= 1'b0;
      bus.wb_addr        <= '0;
      bus.wb_data        <= '0;
      bus.wb_src         <= '0;
      bus.contention_cnt <= '0;
      last               <= SW'(NREQ - 1);
    end else if (accept) begin
      if (grant_any) begin
        bus.wb_valid <= 1'b1;
        // x0 is hardwired zero: keep the retirement pulse, drop the write
        bus.wb_we    <= sel_we && (sel_addr != 5'd0);
        bus.wb_addr  <= sel_addr;
        bus.wb_data  <= sel_data;
        bus.wb_src   <= grant_idx;
        last         <= grant_idx;
      end else begin
        bus.wb_valid <= 1'b0;
        bus.wb_we    <= 1'b0;
      end
      if (contended && (bus.contention_cnt != 16'hFFFF))
        bus.contention_cnt <= bus.contention_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: directed vector table, randomized run against a
// behavioural model, and a counter saturation sequence.
module tb_riscv_wb_arbiter;
  localparam int XLEN = 64;
  localparam int NREQ = 3;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  riscv_wb_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  riscv_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [2:0]   rv;
    logic [2:0]   we;
    logic [14:0]  addr;
    logic [191:0] data;
    logic         stall;
    logic [2:0]   rdy;
    logic         ev;
    logic         ewe;
    logic [4:0]   ea;
    logic [63:0]  ed;
    logic [1:0]   es;
    logic [15:0]  ec;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [2:0] rv, logic [2:0] we,
                              logic [14:0] addr, logic [191:0] data, logic stall,
                              logic [2:0] rdy, logic ev, logic ewe, logic [4:0] ea,
                              logic [63:0] ed, logic [1:0] es, logic [15:0] ec);
    vec_t v;
    v.rst = rst; v.rv = rv; v.we = we; v.addr = addr; v.data = data;
    v.stall = stall; v.rdy = rdy; v.ev = ev; v.ewe = ewe; v.ea = ea;
    v.ed = ed; v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic ewe,
                         input logic [4:0] ea, input logic [63:0] ed,
                         input logic [1:0] es, input logic [15:0] ec);
    chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'(ev));
    chk({tag, "_wb_we"},    64'(bus.wb_we),    64'(ewe));
    chk({tag, "_wb_addr"},  64'(bus.wb_addr),  64'(ea));
    chk({tag, "_wb_data"},  bus.wb_data,       ed);
    chk({tag, "_wb_src"},   64'(bus.wb_src),   64'(es));
    chk({tag, "_cnt"},      64'(bus.contention_cnt), 64'(ec));
  endtask

  // Called at posedge+1: drive, check ready mid-cycle, check registers after edge
  task automatic apply(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    rstn          = !v.rst;
    bus.req_valid = v.rv;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_data  = v.data;
    bus.wb_stall  = v.stall;
    #3;
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(v.rdy));
    @(posedge clk);
    #1;
    chk_out(tag, v.ev, v.ewe, v.ea, v.ed, v.es, v.ec);
  endtask

  vec_t tbl[$];

  // Behavioural model state for the random phase
  int          m_last, m_src, m_cnt;
  bit          m_v, m_we;
  logic [4:0]  m_a;
  logic [63:0] m_d;
  bit          pv[NREQ];
  bit          pwe[NREQ];
  logic [4:0]  pa[NREQ];
  logic [63:0] pd[NREQ];

  task automatic model_reset();
    m_last = NREQ - 1; m_src = 0; m_cnt = 0;
    m_v = 0; m_we = 0; m_a = '0; m_d = '0;
  endtask

  initial begin
    logic [14:0]  a_rr;
    logic [191:0] d_rr;
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.wb_stall = 1'b0;

    a_rr = {5'd12, 5'd11, 5'd10};
    d_rr = {64'hC2, 64'hC1, 64'hC0};

    // rst rv we addr data stall | rdy ev ewe ea ed es ec
    tbl.push_back(mk(1, 3'b000, 3'b000, 15'd0, 192'd0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 15'd0, 192'd0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd3}, {64'h0, 64'h0, 64'h1}, 0,
                     3'b001, 1, 1, 3, 64'h1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, {5'd0, 5'd0, 5'd3}, {64'h0, 64'h0, 64'h1}, 0,
                     3'b000, 0, 0, 3, 64'h1, 0, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 15'd0, 192'd0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    // Round robin from reset: 0,1,2,0,1,2
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b001, 1, 1, 10, 64'hC0, 0, 1));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b010, 1, 1, 11, 64'hC1, 1, 2));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b100, 1, 1, 12, 64'hC2, 2, 3));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b001, 1, 1, 10, 64'hC0, 0, 4));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b010, 1, 1, 11, 64'hC1, 1, 5));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b100, 1, 1, 12, 64'hC2, 2, 6));
    // x0 filter on requester 1
    tbl.push_back(mk(0, 3'b010, 3'b010, 15'd0, {64'h0, 64'hDEAD, 64'h0}, 0,
                     3'b010, 1, 0, 0, 64'hDEAD, 1, 6));
    // Grant requester 2, then stall three cycles with 0 and 1 pending
    tbl.push_back(mk(0, 3'b100, 3'b100, {5'd5, 5'd0, 5'd0}, {64'hA5, 64'h0, 64'h0}, 0,
                     3'b100, 1, 1, 5, 64'hA5, 2, 6));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 3'b011, 3'b011, {5'd0, 5'd4, 5'd3}, {64'h0, 64'hB1, 64'hB0}, 1,
                       3'b000, 1, 1, 5, 64'hA5, 2, 6));
    // Stall release: drain and grant requester 0 at the same edge
    tbl.push_back(mk(0, 3'b011, 3'b011, {5'd0, 5'd4, 5'd3}, {64'h0, 64'hB1, 64'hB0}, 0,
                     3'b001, 1, 1, 3, 64'hB0, 0, 7));
    // Reset in the middle of a stalled writeback with count 4
    tbl.push_back(mk(1, 3'b000, 3'b000, 15'd0, 192'd0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b001, 1, 1, 10, 64'hC0, 0, 1));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b010, 1, 1, 11, 64'hC1, 1, 2));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b100, 1, 1, 12, 64'hC2, 2, 3));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b001, 1, 1, 10, 64'hC0, 0, 4));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 1, 3'b000, 1, 1, 10, 64'hC0, 0, 4));
    tbl.push_back(mk(1, 3'b111, 3'b111, a_rr, d_rr, 1, 3'b000, 0, 0, 0, 64'h0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, a_rr, d_rr, 0, 3'b001, 1, 1, 10, 64'hC0, 0, 1));

    @(posedge clk);
    #1;
    foreach (tbl[n]) apply(tbl[n], n);

    // Randomized run against the model; requesters hold until granted
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.wb_stall = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 0; pwe[i] = 0; pa[i] = '0; pd[i] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit do_rst, stall, accept;
      int g, npend;
      logic [2:0] exp_rdy;
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          pv[i]  = 1;
          pwe[i] = 1'($urandom_range(0, 1));
          pa[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          pd[i]  = {$urandom, $urandom};
        end
        bus.req_valid[i]           = pv[i];
        bus.req_we[i]              = pwe[i];
        bus.req_addr[5*i +: 5]     = pa[i];
        bus.req_data[64*i +: 64]   = pd[i];
      end
      stall  = ($urandom_range(0, 3) == 0);
      do_rst = ($urandom_range(0, 127) == 0);
      bus.wb_stall = stall;
      rstn = !do_rst;
      #3;
      accept = !m_v || !stall;
      g = -1;
      npend = 0;
      for (int i = 0; i < NREQ; i++) if (pv[i]) npend++;
      if (accept && !do_rst)
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && pv[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("rnd_ready", 64'(bus.req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      if (do_rst) begin
        model_reset();
      end else if (accept) begin
        if (npend >= 2 && m_cnt < 65535) m_cnt++;
        if (g >= 0) begin
          m_v = 1; m_we = pwe[g] && (pa[g] != 0); m_a = pa[g]; m_d = pd[g];
          m_src = g; m_last = g; pv[g] = 0;
        end else begin
          m_v = 0; m_we = 0;
        end
      end
      chk_out("rnd", m_v, m_we, m_a, m_d, 2'(m_src), 16'(m_cnt));
    end

    // Saturation: 65540 contended accept cycles, count must stop at FFFF
    rstn = 1'b0;
    bus.wb_stall = 1'b0;
    bus.req_valid = 3'b111;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("sat_start", 64'(bus.contention_cnt), 64'h0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 64'(bus.contention_cnt), 64'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_ffff", 64'(bus.contention_cnt), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_wb_arbiter.md
# riscv_wb_arbiter

Round-robin arbiter sharing the single integer register-file writeback port (valid / we / addr / data) between NREQ producers (ALU, load unit, mul/div). It registers the winning request onto the writeback bus consumed by the register file and by regression monitors such as the x3 (gp) capture checker. It filters writes to x0, honours a downstream stall, and counts contention cycles for performance regression.

## Interface
Parameters:
- XLEN, 64, data width.
- NREQ, 3, number of requesters (2..8).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. One clock; reset is synchronous and active-low.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_we  in  NREQ  write-enable per requester.
- req_addr  in  5*NREQ  destination register; requester i at bits [5i+4:5i].
- req_data  in  XLEN*NREQ  write data; requester i at bits [XLEN*i+XLEN-1:XLEN*i].
- req_ready  out  NREQ  one-hot grant; the request is consumed at the clock edge where valid and ready are both high.
- wb_stall  in  1  downstream cannot take a new writeback this cycle.
- wb_valid  out  1  writeback valid (registered).
- wb_we  out  1  writeback enable (registered; forced 0 for x0).
- wb_addr  out  5  writeback register index (registered).
- wb_data  out  XLEN  writeback data (registered).
- wb_src  out  $clog2(NREQ)  index of the requester that produced the current writeback.
- contention_cnt  out  16  saturating count of contended grant cycles.

## Operation
- Accept condition: accept = !wb_valid || !wb_stall. The output slot is either empty or being drained this cycle.
- Arbitration is combinational and happens only when accept=1.
  - The search starts at (last+1) mod NREQ and wraps upward.
  - The first i with req_valid[i]=1 wins, and req_ready[i]=1.
  - All other req_ready bits are 0.
  - When accept=0, all req_ready bits are 0.
- On a grant of requester i at a clock edge:
  - wb_valid<=1
  - wb_we<=req_we[i] && (req_addr[i]!=0)
  - wb_addr<=req_addr[i]
  - wb_data<=req_data[i]
  - wb_src<=i
  - last<=i
- accept=1 with no req_valid: wb_valid<=0 and wb_we<=0. wb_addr, wb_data and wb_src hold.
- accept=0 (stalled with valid output): every output register holds and last holds.
- The x0 filter clears only wb_we. wb_valid still pulses, so monitors see the retirement.
- contention_cnt increments by 1 on each accept cycle with two or more req_valid bits set. It saturates at 16'hFFFF.
- Requesters must hold req_valid, req_we, req_addr and req_data stable until their grant. Behaviour when a requester withdraws is undefined but must not corrupt the output register. Only granted data is ever captured.
- Fairness: a continuously valid requester is granted within NREQ accept cycles.

## Timing
- Reset (rstn=0 at a clock edge), all registers:
  - wb_valid=0, wb_we=0, wb_addr=0, wb_data=0, wb_src=0
  - contention_cnt=0
  - last=NREQ-1, so requester 0 has first priority after reset.
- During reset, req_ready is held at all-zero.
- Reset mid-stall or mid-burst discards the held writeback with no partial output.
- Latency: request granted at edge N appears on wb_* during cycle N+1. Throughput is one writeback per cycle when wb_stall=0.
- req_ready depends combinationally on req_valid, wb_valid and wb_stall. There is no combinational path from req_data or req_addr to any output.
- Simultaneous events:
  - wb_stall=1 with wb_valid=0 still accepts, because the slot is empty.
  - wb_stall deasserting and a new grant in the same cycle are allowed: the old writeback drains and the new one is loaded at the same edge.
- Pointer wrap: after last=NREQ-1, the search starts at 0.

## Test plan
- Reset then single request: rstn low for 2 cycles, release, then req_valid=3'b001 with addr=3, data=64'h1, we=1. Expect:
  - req_ready=001 in that cycle.
  - Next cycle: wb_valid=1, wb_we=1, wb_addr=3, wb_data=1, wb_src=0.
  - The following idle cycle: wb_valid=0.
- Round-robin: req_valid=3'b111 held for 6 cycles with distinct data. Expect:
  - Grant order 0,1,2,0,1,2.
  - contention_cnt=6.
  - No requester is granted twice before the others.
- x0 filter: requester 1 writes addr=0, data=64'hDEAD, we=1. Expect wb_valid=1, wb_we=0, wb_src=1.
- Stall hold: grant requester 2 (addr=5, data=64'hA5), then wb_stall=1 for 3 cycles with req_valid=3'b011. Expect:
  - wb_* holds addr=5, data=64'hA5.
  - req_ready=000 throughout.
  - Releasing the stall grants requester 0 at the same edge the held writeback drains.
- Reset mid-operation: during a stalled valid writeback with contention_cnt=4, assert rstn=0 for one edge. Expect wb_valid=0, contention_cnt=0, and the next grant going to requester 0.
- Saturation: force 65540 contended accept cycles. Expect contention_cnt=16'hFFFF with no wrap.
